cl_cntr_seq: RTL and testbench

Sequencer that drives the cache-line encryption counter buffer on behalf of the OR1200 data cache. On a line fill it fetches the line's current counter. On a write-back it fetches the counter, commits counter+1, and uses the incremented value. In both cases it hands a `{tag, counter}` seed to the line cipher engine over a valid/ready handshake. It sits between the dcache FSM and the counter buffer, and is the initiator of the counter buffer's eval/store/done protocol.

---
 rtl/cl_cntr_seq_pkg.sv | 21 ++
 rtl/cl_cntr_seq.sv | 138 +++++++++++++
 tb/tb_cl_cntr_seq.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cl_cntr_seq_pkg.sv
// Shared definitions for the cache-line counter sequencer: default widths,
// watchdog limit and the sequencer state encoding.
package cl_cntr_seq_pkg;

  localparam int CNTR_AW_DEF = 21;
  localparam int CNTR_DW_DEF = 16;
  localparam int ADDR_W_DEF  = 32;
  localparam int DCLS_DEF    = 4;
  localparam int WD_LIM_DEF  = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EVAL    = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_CAP     = 3'd3,
    ST_STORE   = 3'd4,
    ST_WAIT_WR = 3'd5,
    ST_SEED    = 3'd6
  } state_e;

endpackage

// File: rtl/cl_cntr_seq.sv
// Drives the counter buffer eval/store protocol for dcache fills and
// write-backs and hands a {tag, counter} seed to the line cipher engine.
module cl_cntr_seq
  import cl_cntr_seq_pkg::*;
#(
  parameter int cntr_aw = CNTR_AW_DEF,
  parameter int cntr_dw = CNTR_DW_DEF,
  parameter int addr_w  = ADDR_W_DEF,
  parameter int dcls    = DCLS_DEF,
  parameter int wd_lim  = WD_LIM_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fill_req,
  input  logic                       wb_req,
  input  logic [addr_w-1:0]          line_addr,
  output logic                       req_ack,
  output logic                       busy,
  output logic                       err,
  output logic                       seed_valid,
  input  logic                       seed_ready,
  output logic [cntr_aw+cntr_dw-1:0] seed,
  output logic                       seed_wb,
  output logic                       cntr_eval,
  output logic                       cntr_store,
  output logic                       cntr_invalid,
  output logic [cntr_aw-1:0]         tag_addr,
  input  logic                       cntr_done,
  input  logic [cntr_dw-1:0]         cache_cntr,
  output state_e                     o_dbg_state
);

  localparam int WD_W = $clog2(wd_lim + 1);

  // Seed handshake: the seed transfers on the rising edge where seed_valid
  // and seed_ready are both high; seed and seed_wb hold while seed_valid is
  // high and seed_ready is low.

  state_e             r_state;
  state_e             w_nxt_state;
  logic [WD_W-1:0]    r_wd;
  logic [cntr_dw-1:0] r_cntr;
  logic               w_can_accept;
  logic               w_accept;
  logic               w_accept_wb;
  logic               w_wd_expire;
  logic               w_in_wait;
  logic               w_unused_addr;

  assign w_in_wait = (r_state == ST_WAIT_RD) || (r_state == ST_WAIT_WR);

  always_comb begin
    w_nxt_state  = r_state;
    w_can_accept = 1'b0;
    w_accept     = 1'b0;
    w_accept_wb  = 1'b0;
    w_wd_expire  = 1'b0;
    case (r_state)
      ST_IDLE:    w_can_accept = 1'b1;
      ST_EVAL:    w_nxt_state = ST_WAIT_RD;
      ST_WAIT_RD: begin
        if (cntr_done) begin
          w_nxt_state = ST_CAP;
        end else if (r_wd == WD_W'(wd_lim - 1)) begin
          w_wd_expire = 1'b1;
          w_nxt_state = ST_IDLE;
        end
      end
      ST_CAP:     w_nxt_state = seed_wb ? ST_STORE : ST_SEED;
      ST_STORE:   w_nxt_state = ST_WAIT_WR;
      ST_WAIT_WR: begin
        if (cntr_done) begin
          w_nxt_state = ST_SEED;
        end else if (r_wd == WD_W'(wd_lim - 1)) begin
          w_wd_expire = 1'b1;
          w_nxt_state = ST_IDLE;
        end
      end
      ST_SEED: begin
        if (seed_valid && seed_ready) begin
          w_nxt_state  = ST_IDLE;
          w_can_accept = 1'b1;
        end
      end
      default:    w_nxt_state = ST_IDLE;
    endcase
    // The handshake edge doubles as an IDLE cycle so a held request is acked next cycle.
    if (w_can_accept && (wb_req || fill_req)) begin
      w_accept    = 1'b1;
      w_accept_wb = wb_req;
      w_nxt_state = ST_EVAL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_wd    <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_wd    <= (w_in_wait && (w_nxt_state == r_state)) ? r_wd + WD_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ack    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      seed_valid <= 1'b0;
      seed_wb    <= 1'b0;
      cntr_eval  <= 1'b0;
      cntr_store <= 1'b0;
      tag_addr   <= '0;
      r_cntr     <= '0;
    end else begin
      req_ack    <= w_accept;
      busy       <= (w_nxt_state != ST_IDLE);
      err        <= w_wd_expire;
      seed_valid <= (w_nxt_state == ST_SEED);
      cntr_eval  <= (r_state == ST_EVAL);
      cntr_store <= (r_state == ST_CAP) && seed_wb;
      if (w_accept) begin
        tag_addr <= line_addr[dcls+cntr_aw-1:dcls];
        seed_wb  <= w_accept_wb;
      end
      if (r_state == ST_CAP) begin
        r_cntr <= seed_wb ? cache_cntr + cntr_dw'(1) : cache_cntr;
      end
    end
  end

  assign seed          = {tag_addr, r_cntr};
  assign cntr_invalid  = 1'b0;
  assign o_dbg_state   = r_state;
  assign w_unused_addr = ^{line_addr[addr_w-1:dcls+cntr_aw], line_addr[dcls-1:0]};

endmodule

// File: tb/tb_cl_cntr_seq.sv
// Bench for cl_cntr_seq: counter buffer responder, request drivers and a
// seed scoreboard fed by a per-tag counter map.
module tb_cl_cntr_seq;
  import cl_cntr_seq_pkg::*;

  localparam int AW = 21;
  localparam int DW = 16;
  localparam int ADW = 32;
  localparam int DCLS = 4;
  localparam int WD_LIM = 7;
  localparam logic [AW-1:0] TAG_A = 21'h0ABCD;
  localparam logic [AW-1:0] TAG_W = 21'h1F00E;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              fill_req = 1'b0;
  logic              wb_req = 1'b0;
  logic [ADW-1:0]    line_addr = '0;
  logic              seed_ready = 1'b0;
  logic              req_ack, busy, err, seed_valid, seed_wb;
  logic              cntr_eval, cntr_store, cntr_invalid;
  logic [AW+DW-1:0]  seed;
  logic [AW-1:0]     tag_addr;
  logic              cntr_done = 1'b0;
  logic [DW-1:0]     cache_cntr = '0;
  state_e            dbg_state;

  cl_cntr_seq #(.cntr_aw(AW), .cntr_dw(DW), .addr_w(ADW), .dcls(DCLS), .wd_lim(WD_LIM)) dut (
    .clk(clk), .rst(rst), .fill_req(fill_req), .wb_req(wb_req), .line_addr(line_addr),
    .req_ack(req_ack), .busy(busy), .err(err), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed(seed), .seed_wb(seed_wb), .cntr_eval(cntr_eval), .cntr_store(cntr_store),
    .cntr_invalid(cntr_invalid), .tag_addr(tag_addr), .cntr_done(cntr_done),
    .cache_cntr(cache_cntr), .o_dbg_state(dbg_state)
  );

  // ---------------- counter buffer responder ----------------
  // Tags used by the bench have distinct low nibbles, so 16 entries suffice.
  logic [DW-1:0] bmem [16] = '{13: 16'h1234, 14: 16'hFFFF, default: 16'h0000};
  bit            drop_done = 1'b0;
  logic          bf_rd_pend = 1'b0;
  logic          bf_wr_pend = 1'b0;
  logic [3:0]    bf_idx = '0;
  logic [DW-1:0] bf_wdata = '0;

  always @(posedge clk) begin
    cntr_done  <= 1'b0;
    bf_rd_pend <= 1'b0;
    if (bf_wr_pend) begin
      bmem[bf_idx] <= bf_wdata;
      cntr_done    <= 1'b1;
      bf_wr_pend   <= 1'b0;
    end
    if (bf_rd_pend) cache_cntr <= bmem[bf_idx];
    if (cntr_eval && !drop_done) begin
      cntr_done  <= 1'b1;
      bf_rd_pend <= 1'b1;
      bf_idx     <= tag_addr[3:0];
    end
    if (cntr_store) begin
      bf_wr_pend <= 1'b1;
      bf_wdata   <= seed[DW-1:0];
      bf_idx     <= tag_addr[3:0];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] mmem [16] = '{13: 16'h1234, 14: 16'hFFFF, default: 16'h0000};
  logic [AW+DW:0] exp_q [$];
  logic [AW-1:0] pool [4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // A fill sees the stored counter; a write-back sees and commits counter+1 mod 2^16.
  task automatic push_exp(input bit wb, input logic [AW-1:0] t);
    logic [DW-1:0] c;
    c = mmem[t[3:0]];
    if (wb) begin
      c = c + 16'd1;
      mmem[t[3:0]] = c;
    end
    exp_q.push_back({wb, t, c});
  endtask

  function automatic logic [ADW-1:0] mk_addr(input logic [AW-1:0] t);
    logic [6:0] hi;
    logic [3:0] lo;
    hi = 7'($urandom_range(0, 127));
    lo = 4'($urandom_range(0, 15));
    return {hi, t, lo};
  endfunction

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {req_ack, busy, err, seed_valid, seed_wb, cntr_eval, cntr_store, cntr_invalid}, 0);
    check({name, "_seed"}, seed, 0);
    check({name, "_tag"}, tag_addr, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ack(output int c);
    c = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_ack) begin
        c = cyc;
        break;
      end
    end
    check("req_ack_seen", (c >= 0), 1);
  endtask

  // Called at the ack cycle; returns at the cycle whose closing edge completes the handshake.
  task automatic run_txn(input bit wb, input int delay, input int c0, output int hs);
    int n_ev, ev_c, st_c, sv_c;
    bit got, stable;
    logic [AW+DW-1:0] held;
    logic [AW+DW:0] e;
    n_ev = 0; ev_c = -1; st_c = -1; sv_c = -1; got = 0; hs = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cntr_eval) begin n_ev++; ev_c = cyc - c0; end
      if (cntr_store) st_c = cyc - c0;
      if (seed_valid) begin got = 1; sv_c = cyc - c0; break; end
    end
    check("seed_valid_seen", got, 1);
    if (!got) return;
    check("eval_count", n_ev, 1);
    check("eval_cycle", ev_c, 1);
    check("store_cycle", st_c, wb ? 4 : -1);
    check("seed_valid_cycle", sv_c, wb ? 7 : 4);
    if (delay > 0) begin
      held = seed;
      stable = 1;
      for (int d = 0; d < delay; d++) begin
        if (seed !== held || seed_wb !== wb || !seed_valid || req_ack) stable = 0;
        @(negedge clk);
      end
      check("backpressure_stable", stable, 1);
    end
    seed_ready = 1'b1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("seed", {seed_wb, seed}, e);
    end
    hs = cyc;
  endtask

  task automatic do_req(input bit wb, input logic [AW-1:0] t, input int delay);
    int c0, hs;
    if (delay == 0) seed_ready = 1'b1;
    line_addr = mk_addr(t);
    if (wb) wb_req = 1'b1; else fill_req = 1'b1;
    wait_ack(c0);
    wb_req = 1'b0;
    fill_req = 1'b0;
    if (delay > 0) seed_ready = 1'b0;
    if (c0 < 0) return;
    check("tag_addr", tag_addr, t);
    check("seed_wb_at_ack", seed_wb, wb);
    line_addr = $urandom;
    push_exp(wb, t);
    run_txn(wb, delay, c0, hs);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, c1, hs, err_c, n_err;
    bit sv_seen, seen, busy_at_err, wb;
    int d;
    logic [AW-1:0] t;
    for (int i = 0; i < 4; i++) pool[i] = {17'($urandom), 4'(i)};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    @(negedge clk);

    do_req(0, TAG_A, 0);
    do_req(1, TAG_A, 0);
    check("buf_after_wb", bmem[13], 16'h1235);
    do_req(0, TAG_A, 0);

    do_req(1, TAG_W, 0);
    check("buf_wrap", bmem[14], 16'h0000);

    // simultaneous requests: write-back first, fill right after its handshake
    @(negedge clk);
    seed_ready = 1'b1;
    line_addr = mk_addr(TAG_A);
    wb_req = 1'b1;
    fill_req = 1'b1;
    wait_ack(c0);
    wb_req = 1'b0;
    check("simul_first_wb", seed_wb, 1);
    push_exp(1, TAG_A);
    run_txn(1, 0, c0, hs);
    wait_ack(c1);
    fill_req = 1'b0;
    check("simul_fill_after_hs", c1, hs + 1);
    check("simul_spacing", c1 - c0, 8);
    check("simul_second_fill", seed_wb, 0);
    push_exp(0, TAG_A);
    run_txn(0, 0, c1, hs);

    // backpressure with a pending fill
    @(negedge clk);
    line_addr = mk_addr(pool[2]);
    wb_req = 1'b1;
    wait_ack(c0);
    wb_req = 1'b0;
    seed_ready = 1'b0;
    push_exp(1, pool[2]);
    line_addr = mk_addr(pool[3]);
    fill_req = 1'b1;
    run_txn(1, 10, c0, hs);
    wait_ack(c1);
    fill_req = 1'b0;
    check("bp_ack_after_hs", c1, hs + 1);
    push_exp(0, pool[3]);
    run_txn(0, 0, c1, hs);

    // watchdog
    @(negedge clk);
    drop_done = 1'b1;
    line_addr = mk_addr(pool[0]);
    fill_req = 1'b1;
    wait_ack(c0);
    fill_req = 1'b0;
    err_c = -1; n_err = 0; sv_seen = 0; busy_at_err = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (err) begin
        n_err++;
        if (err_c < 0) begin err_c = cyc - c0; busy_at_err = busy; end
      end
      if (seed_valid) sv_seen = 1;
    end
    check("wd_err_cycle", err_c, 1 + WD_LIM);
    check("wd_err_pulses", n_err, 1);
    check("wd_busy_at_err", busy_at_err, 0);
    check("wd_no_seed", sv_seen, 0);
    check("wd_state_idle", dbg_state, ST_IDLE);
    drop_done = 1'b0;

    // reset while the counter store strobe is up
    @(negedge clk);
    line_addr = mk_addr(pool[1]);
    wb_req = 1'b1;
    wait_ack(c0);
    wb_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cntr_store) begin seen = 1; break; end
    end
    check("rst_store_seen", seen, 1);
    #1 rst = 1'b0;
    #1 check_all_zero("rst_mid");
    check("rst_mid_state", dbg_state, ST_IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_req(0, pool[1], 0);

    // randomized traffic over a small tag pool
    for (int n = 0; n < 30; n++) begin
      wb = 1'($urandom_range(0, 1));
      t = pool[$urandom_range(0, 3)];
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_req(wb, t, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // ---------------- final report ----------------
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) check($sformatf("buf_entry_%0d", i), bmem[i], mmem[i]);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
